sdram_slave_model: RTL and testbench

SDRAM_SLAVE_MODEL -- requirements
Module: sdram_slave_model

---
 rtl/sdram_slave_model.sv | 128 ++++++++++++
 tb/tb_sdram_slave_model.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_slave_model.sv
// Behavioural SDRAM-controller slave: byte-laned word memory, fixed-latency read
// pipeline with bounded outstanding reads, periodic refresh stalls and a sticky protocol-error flag.
module sdram_slave_model #(
   parameter int unsigned ADDR_BITS    = 8,
   parameter int unsigned READ_LATENCY = 3,
   parameter int unsigned MAX_PENDING  = 4,
   parameter int unsigned STALL_PERIOD = 0,
   parameter int unsigned STALL_LEN    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [24:0] sdr_slave_address,
   input  logic [1:0]  sdr_slave_byteenable_n,
   input  logic        sdr_slave_chipselect,
   input  logic [15:0] sdr_slave_writedata,
   input  logic        sdr_slave_read_n,
   input  logic        sdr_slave_write_n,
   output logic [15:0] sdr_slave_readdata,
   output logic        sdr_slave_readdatavalid,
   output logic        sdr_slave_waitrequest,
   output logic        proto_err
);

   localparam int unsigned DEPTH       = 1 << ADDR_BITS;
   localparam int unsigned SCW         = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
   localparam int unsigned STALL_START = (STALL_PERIOD > STALL_LEN) ? STALL_PERIOD - STALL_LEN : 0;
   localparam int unsigned STALL_END   = (STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0;
   localparam logic [SCW-1:0] STALL_LAST  = SCW'(STALL_END);
   localparam logic [SCW-1:0] STALL_FIRST = SCW'(STALL_START);
   localparam logic [2:0]     PEND_MAX    = 3'(MAX_PENDING);

   logic [ADDR_BITS-1:0] word_addr;
   logic                 rd_accept;
   logic                 wr_accept;
   logic                 illegal;
   logic                 stall_active;
   logic                 unused_bits;

   logic [15:0]             mem_q [DEPTH];
   logic [15:0]             rdata_pipe_q [READ_LATENCY];
   logic [15:0]             rdata_pipe_d [READ_LATENCY];
   logic [READ_LATENCY-1:0] vld_q;
   logic [READ_LATENCY-1:0] vld_d;
   logic [2:0]              pending_q;
   logic [2:0]              pending_d;
   logic [SCW-1:0]          stall_cnt_q;
   logic [SCW-1:0]          stall_cnt_d;
   logic                    proto_err_q;
   logic                    proto_err_d;

   // Backpressure comes only from flops, so no input can reach waitrequest.
   always_comb begin
      sdr_slave_waitrequest   = (pending_q == PEND_MAX) || stall_active;
      sdr_slave_readdatavalid = vld_q[READ_LATENCY-1];
      sdr_slave_readdata      = sdr_slave_readdatavalid ? rdata_pipe_q[READ_LATENCY-1] : '0;
      proto_err               = proto_err_q;
   end

   always_comb begin
      word_addr   = sdr_slave_address[ADDR_BITS-1:0];
      unused_bits = ^{sdr_slave_address[24:ADDR_BITS], stall_cnt_q};
      rd_accept   = sdr_slave_chipselect && !sdr_slave_read_n && sdr_slave_write_n
                    && !sdr_slave_waitrequest && !reset;
      wr_accept   = sdr_slave_chipselect && !sdr_slave_write_n && sdr_slave_read_n
                    && !sdr_slave_waitrequest && !reset;
      illegal     = sdr_slave_chipselect && !sdr_slave_read_n && !sdr_slave_write_n;
   end

   // Data is captured at acceptance, so later writes never leak into an issued read.
   always_comb begin
      vld_d           = '0;
      rdata_pipe_d[0] = rd_accept ? mem_q[word_addr] : '0;
      vld_d[0]        = rd_accept;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
         vld_d[i]        = vld_q[i-1];
         rdata_pipe_d[i] = rdata_pipe_q[i-1];
      end
   end

   always_comb begin
      pending_d = pending_q;
      case ({rd_accept, sdr_slave_readdatavalid})
         2'b10:   pending_d = pending_q + 3'd1;
         2'b01:   pending_d = pending_q - 3'd1;
         default: pending_d = pending_q;
      endcase
      proto_err_d = proto_err_q | illegal;
   end

   if (STALL_PERIOD != 0) begin : g_stall
      always_comb begin
         stall_cnt_d  = (stall_cnt_q == STALL_LAST) ? '0 : stall_cnt_q + 1'b1;
         stall_active = (stall_cnt_q >= STALL_FIRST);
      end
   end else begin : g_no_stall
      always_comb begin
         stall_cnt_d  = '0;
         stall_active = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q       <= '0;
         pending_q   <= '0;
         stall_cnt_q <= '0;
         proto_err_q <= 1'b0;
         for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            rdata_pipe_q[i] <= '0;
         end
      end else begin
         vld_q        <= vld_d;
         pending_q    <= pending_d;
         stall_cnt_q  <= stall_cnt_d;
         proto_err_q  <= proto_err_d;
         rdata_pipe_q <= rdata_pipe_d;
      end
   end

   // Memory contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         if (!sdr_slave_byteenable_n[0]) mem_q[word_addr][7:0]  <= sdr_slave_writedata[7:0];
         if (!sdr_slave_byteenable_n[1]) mem_q[word_addr][15:8] <= sdr_slave_writedata[15:8];
      end
   end

endmodule

// File: tb/tb_sdram_slave_model.sv
// Scoreboard bench for sdram_slave_model: a shadow memory predicts read data at
// acceptance; a negedge monitor pops expectations and checks data, latency and idle outputs.
module tb_sdram_slave_model;

   localparam int unsigned RL      = 3;
   localparam int unsigned LAT_NS  = (RL - 1) * 10 + 5;

   logic        clk = 1'b0;
   logic        reset;
   logic [24:0] addr;
   logic [1:0]  be_n;
   logic        cs;
   logic [15:0] wdata;
   logic        rd_n;
   logic        wr_n;
   logic [15:0] rdata;
   logic        rdv;
   logic        waitreq;
   logic        perr;

   typedef struct {
      logic [15:0] data;
      time         t_acc;
   } sb_t;

   sb_t         sb[$];
   time         vld_times[$];
   logic [15:0] shadow [256];
   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   always #5 clk = ~clk;

   sdram_slave_model #(
      .ADDR_BITS   (8),
      .READ_LATENCY(RL),
      .MAX_PENDING (2),
      .STALL_PERIOD(16),
      .STALL_LEN   (2)
   ) u_dut (
      .clk                    (clk),
      .reset                  (reset),
      .sdr_slave_address      (addr),
      .sdr_slave_byteenable_n (be_n),
      .sdr_slave_chipselect   (cs),
      .sdr_slave_writedata    (wdata),
      .sdr_slave_read_n       (rd_n),
      .sdr_slave_write_n      (wr_n),
      .sdr_slave_readdata     (rdata),
      .sdr_slave_readdatavalid(rdv),
      .sdr_slave_waitrequest  (waitreq),
      .proto_err              (perr)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
   endtask

   // Callers enter and leave at a negedge; waitrequest is flop-driven so it holds until the edge.
   task automatic wr(input logic [24:0] a, input logic [15:0] d, input logic [1:0] ben,
                     output time t_acc);
      int unsigned guard = 0;
      cs = 1'b1; wr_n = 1'b0; rd_n = 1'b1; addr = a; wdata = d; be_n = ben;
      while (waitreq && guard < 64) begin
         @(negedge clk);
         guard++;
      end
      t_acc = 0;
      if (guard >= 64) begin
         check("wr_wait_timeout", guard, 0);
      end else begin
         @(posedge clk);
         t_acc = $time;
         if (!ben[0]) shadow[a[7:0]][7:0]  = d[7:0];
         if (!ben[1]) shadow[a[7:0]][15:8] = d[15:8];
         @(negedge clk);
      end
      cs = 1'b0; wr_n = 1'b1;
   endtask

   task automatic rd(input logic [24:0] a, input logic [1:0] ben, output time t_acc);
      int unsigned guard = 0;
      sb_t e;
      cs = 1'b1; rd_n = 1'b0; wr_n = 1'b1; addr = a; be_n = ben;
      while (waitreq && guard < 64) begin
         @(negedge clk);
         guard++;
      end
      t_acc = 0;
      if (guard >= 64) begin
         check("rd_wait_timeout", guard, 0);
      end else begin
         @(posedge clk);
         t_acc   = $time;
         e.data  = shadow[a[7:0]];
         e.t_acc = $time;
         sb.push_back(e);
         @(negedge clk);
      end
      cs = 1'b0; rd_n = 1'b1;
   endtask

   always @(negedge clk) begin
      sb_t e;
      if (!reset) begin
         if (sb.size() == 0) begin
            check("stray_valid", rdv, 0);
            check("idle_rdata", rdata, 0);
         end else if (rdv) begin
            e = sb.pop_front();
            check("rdata", rdata, e.data);
            check("latency", 32'($time - e.t_acc), LAT_NS);
            vld_times.push_back($time);
         end else begin
            check("idle_rdata", rdata, 0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1);
   end

   initial begin
      time t, t0, t1, t2, t3;
      reset = 1'b1; cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1; addr = '0; wdata = '0; be_n = 2'b11;
      #1;
      check("rst_rdv", rdv, 0);
      check("rst_rdata", rdata, 0);
      check("rst_wait", waitreq, 0);
      check("rst_perr", perr, 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      t0 = $time;

      wr(25'd5, 16'hBEEF, 2'b00, t);
      check("first_accept", 32'(t - t0), 5);
      rd(25'd5, 2'b00, t);

      for (int unsigned i = 0; i < 16; i++) begin
         if (i != 5) wr(25'(i), 16'(16'h1000 + i * 16'h0111), 2'b00, t);
      end

      wr(25'd7, 16'h1234, 2'b00, t);
      wr(25'd7, 16'hAB00, 2'b01, t);
      rd(25'd7, 2'b00, t);
      wr(25'h107, 16'h1234, 2'b00, t);
      rd(25'd7, 2'b00, t);
      wr(25'd7, 16'hFFFF, 2'b11, t);
      rd(25'h1207, 2'b11, t);
      wr(25'd8, 16'h00CD, 2'b10, t);
      rd(25'd8, 2'b01, t);
      repeat (6) @(negedge clk);

      vld_times.delete();
      rd(25'd3, 2'b00, t1);
      rd(25'd4, 2'b00, t2);
      if (t2 - t1 <= 20) check("wait_full", waitreq, 1);
      rd(25'd6, 2'b00, t3);
      repeat (8) @(negedge clk);
      check("vld_cnt", vld_times.size(), 3);
      if (vld_times.size() > 0) check("rd3_after_v1", t3 > vld_times[0], 1);

      cs = 1'b0; rd_n = 1'b0; wr_n = 1'b0; addr = 25'd10; wdata = 16'hDEAD; be_n = 2'b00;
      repeat (2) @(negedge clk);
      rd_n = 1'b1; wr_n = 1'b1;
      check("cs0_perr", perr, 0);
      rd(25'd10, 2'b00, t);
      repeat (6) @(negedge clk);

      check("perr_before", perr, 0);
      cs = 1'b1; rd_n = 1'b0; wr_n = 1'b0; addr = 25'd9; wdata = 16'hDEAD; be_n = 2'b00;
      @(negedge clk);
      cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
      check("perr_set", perr, 1);
      repeat (4) @(negedge clk);
      check("perr_sticky", perr, 1);
      rd(25'd9, 2'b00, t);
      repeat (6) @(negedge clk);
      check("perr_held", perr, 1);

      rd(25'd1, 2'b00, t);
      rd(25'd2, 2'b00, t);
      rd(25'd3, 2'b00, t);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_rdv", rdv, 0);
      check("arst_rdata", rdata, 0);
      check("arst_wait", waitreq, 0);
      check("arst_perr", perr, 0);
      sb.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;

      for (int unsigned j = 0; j < 48; j++) begin
         sb_t e;
         check("stall_wait", waitreq, 32'((j % 16) >= 14));
         if (j == 13) begin
            cs = 1'b1; rd_n = 1'b0; wr_n = 1'b1; addr = 25'd5; be_n = 2'b00;
         end
         if (j == 14) begin
            e.data  = shadow[5];
            e.t_acc = $time - 5;
            sb.push_back(e);
            cs = 1'b0; rd_n = 1'b1;
         end
         @(negedge clk);
      end
      repeat (6) @(negedge clk);
      check("sb_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
